// File: rtl/in_fifo_gen2.sv
// in_fifo_gen2: single-clock multi-channel input FIFO with optional 4:8 packing.
// Buffers NUM_CH channels of DW bits; PACK=1 joins two beats per entry.
//
// Ports:
//   CLK, RESET      clock, async active-high reset
//   FLUSH           sync clear of pointers, count, held half-beat
//   WREN, D         write beat; channel i at D[i*DW +: DW]
//   RDEN, Q         pop; Q registered, channel i at Q[i*QW +: QW]
//   EMPTY, FULL     COUNT==0, COUNT==DEPTH
//   ALMOSTEMPTY     COUNT<=AE_VAL
//   ALMOSTFULL      COUNT>=DEPTH-AF_VAL
//   PARTIAL         first beat held, waiting for its pair (PACK=1)
//   COUNT           stored entries
//   OVF, UNF        sticky error flags, only with IN_FIFO_GEN2_ERR_EN
//
// Optional feature macro: IN_FIFO_GEN2_ERR_EN (adds OVF/UNF).

module in_fifo_gen2 #(
  parameter  int NUM_CH = 10,
  parameter  int DW     = 4,
  parameter  int DEPTH  = 8,
  parameter  int PACK   = 1,
  parameter  int AE_VAL = 1,
  parameter  int AF_VAL = 1,
  localparam int QW     = (PACK != 0) ? 2*DW : DW,
  localparam int CW     = $clog2(DEPTH+1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 WREN,
  input  logic [NUM_CH*DW-1:0] D,
  input  logic                 RDEN,
  output logic [NUM_CH*QW-1:0] Q,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 ALMOSTEMPTY,
  output logic                 ALMOSTFULL,
  output logic                 PARTIAL,
`ifdef IN_FIFO_GEN2_ERR_EN
  output logic                 OVF,
  output logic                 UNF,
`endif
  output logic [CW-1:0]        COUNT
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int EW = NUM_CH*QW;
  localparam bit PK = (PACK != 0);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_VAL);
  localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH-AF_VAL);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          part;
  logic          empty_c;
  logic          full_c;
  logic          wr_ok;
  logic          rd_ok;
  logic          push;
  logic [EW-1:0] wentry;
  logic [EW-1:0] mem [DEPTH];

  // Depth need not be a power of two, so wrap
  // on an explicit compare with the last slot.
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty_c = (cnt == '0);
  assign full_c  = (cnt == CNT_FULL);

  assign wr_ok = WREN & ~full_c & ~FLUSH;
  assign rd_ok = RDEN & ~empty_c & ~FLUSH;

  // In packed mode only the second beat of a
  // pair creates an entry.
  assign push = wr_ok & (~PK | part);

  if (PK) begin : g_pack
    logic [NUM_CH*DW-1:0] hold;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        hold <= '0;
        part <= 1'b0;
      end else if (FLUSH) begin
        hold <= '0;
        part <= 1'b0;
      end else if (wr_ok) begin
        if (!part) begin
          hold <= D;
        end
        part <= ~part;
      end
    end

    // First-arrived beat sits in the low half.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign wentry[c*QW +: QW] =
        {D[c*DW +: DW], hold[c*DW +: DW]};
    end
  end else begin : g_flat
    assign part   = 1'b0;
    assign wentry = D;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wentry;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      Q      <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= nxt(rd_ptr);
        Q      <= mem[rd_ptr];
      end
      unique case ({push, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef IN_FIFO_GEN2_ERR_EN
  // Sticky: refused requests are remembered
  // until RESET or FLUSH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else if (FLUSH) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      if (WREN && full_c) begin
        OVF <= 1'b1;
      end
      if (RDEN && empty_c) begin
        UNF <= 1'b1;
      end
    end
  end
`endif

  assign EMPTY       = empty_c;
  assign FULL        = full_c;
  assign ALMOSTEMPTY = (cnt <= CNT_AE);
  assign ALMOSTFULL  = (cnt >= CNT_AF);
  assign PARTIAL     = part;
  assign COUNT       = cnt;

endmodule
